// File: rtl/dp_ram_arbiter_if.sv
// One master's request/response channel into the dual-master RAM arbiter.
// Signal suffixes are from the arbiter's point of view.
interface dp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);
  logic                  req_i;
  logic                  we_i;
  logic [NUM_COL-1:0]    be_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Two-master round-robin arbiter onto a single RAM port; clears the whole RAM
// after reset or on request before arbitration starts.
//
//   state | meaning
//   INIT  | writing zero to every address, clr_cnt walks 0..2^ADDR_WIDTH-1
//   ARB   | clear complete, masters arbitrated onto the RAM port
module dp_ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req_i,
  output logic                  init_done_o,
  dp_ram_arbiter_if.slave       m0,
  dp_ram_arbiter_if.slave       m1,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [NUM_COL-1:0]    ram_be_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic {ST_INIT, ST_ARB} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  last_q, last_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  gnt_m0, gnt_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      last_q    <= 1'b1;
      rvalid_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    last_d      = last_q;
    gnt_m0      = 1'b0;
    gnt_m1      = 1'b0;
    init_done_o = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    unique case (state_q)
      ST_INIT: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_be_o   = '1;
        ram_addr_o = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = ST_ARB;
      end
      ST_ARB: begin
        init_done_o = 1'b1;
        if (init_req_i) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end else begin
          // On contention the master that did not win last time goes first.
          if (m0.req_i && (!m1.req_i || last_q)) gnt_m0 = 1'b1;
          else if (m1.req_i)                     gnt_m1 = 1'b1;

          if (gnt_m0) begin
            last_d      = 1'b0;
            ram_en_o    = 1'b1;
            ram_we_o    = m0.we_i;
            ram_be_o    = m0.we_i ? m0.be_i : '1;
            ram_addr_o  = m0.addr_i;
            ram_wdata_o = m0.wdata_i;
          end else if (gnt_m1) begin
            last_d      = 1'b1;
            ram_en_o    = 1'b1;
            ram_we_o    = m1.we_i;
            ram_be_o    = m1.we_i ? m1.be_i : '1;
            ram_addr_o  = m1.addr_i;
            ram_wdata_o = m1.wdata_i;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    rvalid_d = {gnt_m1, gnt_m0};
  end

  assign m0.gnt_o    = gnt_m0;
  assign m1.gnt_o    = gnt_m1;
  assign m0.rvalid_o = rvalid_q[0];
  assign m1.rvalid_o = rvalid_q[1];
  assign m0.rdata_o  = rvalid_q[0] ? ram_rdata_i : '0;
  assign m1.rdata_o  = rvalid_q[1] ? ram_rdata_i : '0;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a 16-word registered RAM model.
module tb_dp_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic          init_done;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [DW-1:0] mem [16];
  int            errors = 0;
  int            checks = 0;

  dp_ram_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
  dp_ram_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();

  dp_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .init_req_i(init_req), .init_done_o(init_done),
    .m0(m0_if), .m1(m1_if),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: garbage while in reset so the clear has something to erase.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_A5A5;
      ram_rdata <= 32'hA5A5_A5A5;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int c = 0; c < 4; c++)
          if (ram_be[c]) mem[ram_addr][c*8 +: 8] <= ram_wdata[c*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic [3:0] be,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (m == 0) begin
      m0_if.req_i = req; m0_if.we_i = we; m0_if.be_i = be;
      m0_if.addr_i = addr; m0_if.wdata_i = wd;
    end else begin
      m1_if.req_i = req; m1_if.we_i = we; m1_if.be_i = be;
      m1_if.addr_i = addr; m1_if.wdata_i = wd;
    end
  endtask

  function automatic logic [41:0] bus_now();
    return {ram_en, ram_we, ram_be, ram_addr, ram_wdata};
  endfunction

  function automatic logic [41:0] bus_exp(input logic en, input logic we, input logic [3:0] be,
                                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    return {en, we, be, addr, wd};
  endfunction

  function automatic logic [1:0] gnts();
    return {m1_if.gnt_o, m0_if.gnt_o};
  endfunction

  function automatic logic [1:0] rvs();
    return {m1_if.rvalid_o, m0_if.rvalid_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] prev_g;
    rst = 1'b1;
    init_req = 1'b0;
    drv(0, 0, 0, 4'h0, 0, 0);
    drv(1, 0, 0, 4'h0, 0, 0);
    repeat (2) step();

    // Reset state
    @(negedge clk);
    chk("rst_done",  64'(init_done), 64'(0));
    chk("rst_gnt",   64'(gnts()), 64'(0));
    chk("rst_rv",    64'(rvs()), 64'(0));
    chk("rst_rdata", 64'({m1_if.rdata_o, m0_if.rdata_o}), 64'(0));
    step();
    rst = 1'b0;

    // Power-up clear: 16 zero writes, addresses 0..15
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr", 64'({init_done, gnts(), bus_now()}),
          64'({1'b0, 2'b00, bus_exp(1, 1, 4'hF, AW'(i), 0)}));
      step();
    end
    @(negedge clk);
    chk("clr_done", 64'(init_done), 64'(1));
    chk("idle_bus", 64'(bus_now()), 64'(0));

    // Continuous contention: m0 reads 3, m1 reads 9; m0 wins first
    step();
    drv(0, 1, 0, 4'h0, 4'd3, 0);
    drv(1, 1, 0, 4'h0, 4'd9, 0);
    prev_g = 2'b00;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        drv(0, 0, 0, 4'h0, 0, 0);
        drv(1, 0, 0, 4'h0, 0, 0);
      end
      @(negedge clk);
      if (k < 4) begin
        chk("cont_gnt", 64'(gnts()), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
        chk("cont_bus", 64'(bus_now()),
            64'(bus_exp(1, 0, 4'hF, (k % 2 == 0) ? 4'd3 : 4'd9, 0)));
      end
      if (k > 0) chk("cont_rv", 64'(rvs()), 64'(prev_g));
      chk("cont_rdata", 64'({m1_if.rdata_o, m0_if.rdata_o}), 64'(0));
      prev_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
    end

    // Byte-masked write then read back
    drv(0, 1, 1, 4'b0011, 4'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_gnt", 64'(gnts()), 64'(2'b01));
    chk("wr_bus", 64'(bus_now()), 64'(bus_exp(1, 1, 4'b0011, 4'd5, 32'hDEAD_BEEF)));
    step();
    drv(0, 1, 0, 4'h0, 4'd5, 0);
    @(negedge clk);
    chk("rd_gnt", 64'(gnts()), 64'(2'b01));
    chk("wr_rv",  64'(rvs()), 64'(2'b01));
    chk("rd_bus", 64'(bus_now()), 64'(bus_exp(1, 0, 4'hF, 4'd5, 0)));
    step();
    drv(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk("rd_rv",    64'(rvs()), 64'(2'b01));
    chk("rd_data",  64'(m0_if.rdata_o), 64'(32'h0000_BEEF));
    chk("rd_other", 64'(m1_if.rdata_o), 64'(0));
    step();

    // m0 write followed immediately by m1 read: responses back to back
    drv(0, 1, 1, 4'hF, 4'd6, 32'h1234_5678);
    @(negedge clk);
    chk("b2b_gnt0", 64'(gnts()), 64'(2'b01));
    step();
    drv(0, 0, 0, 4'h0, 0, 0);
    drv(1, 1, 0, 4'h0, 4'd6, 0);
    @(negedge clk);
    chk("b2b_gnt1", 64'(gnts()), 64'(2'b10));
    chk("b2b_rv0",  64'(rvs()), 64'(2'b01));
    step();
    drv(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk("b2b_rv1",   64'(rvs()), 64'(2'b10));
    chk("b2b_data1", 64'(m1_if.rdata_o), 64'(32'h1234_5678));
    step();

    // Re-clear request while m1 is requesting
    drv(1, 1, 0, 4'h0, 4'd6, 0);
    init_req = 1'b1;
    @(negedge clk);
    chk("ireq_cycle", 64'({gnts(), ram_en, init_done}), 64'({2'b00, 1'b0, 1'b1}));
    step();
    init_req = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (init_done) break;
      chk("reinit_gnt", 64'(gnts()), 64'(0));
      n++;
      step();
    end
    chk("reinit_len",  64'(n), 64'(16));
    chk("reinit_gnt1", 64'(gnts()), 64'(2'b10));
    step();
    drv(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk("reinit_rv",   64'(rvs()), 64'(2'b10));
    chk("reinit_data", 64'(m1_if.rdata_o), 64'(0));
    step();

    // Reset with a read response pending: response is discarded
    drv(0, 1, 0, 4'h0, 4'd3, 0);
    @(negedge clk);
    chk("pend_gnt", 64'(gnts()), 64'(2'b01));
    #2 rst = 1'b1;
    #1 chk("pend_rst_rv", 64'({rvs(), init_done}), 64'(0));
    @(negedge clk);
    chk("pend_rv_after", 64'({rvs(), m0_if.rdata_o}), 64'(0));
    step();
    rst = 1'b0;
    drv(0, 0, 0, 4'h0, 0, 0);

    // Reset mid-clear at clr_cnt=7 restarts from address 0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_clr", 64'({rvs(), bus_now()}), 64'({2'b00, bus_exp(1, 1, 4'hF, AW'(i), 0)}));
      if (i < 7) step();
    end
    #1 rst = 1'b1;
    #1 chk("mid_rst_addr", 64'(ram_addr), 64'(0));
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("restart_clr", 64'({init_done, rvs(), bus_now()}),
          64'({1'b0, 2'b00, bus_exp(1, 1, 4'hF, AW'(i), 0)}));
      step();
    end
    @(negedge clk);
    chk("restart_done", 64'(init_done), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dp_ram_arbiter.md
DP_RAM_ARBITER -- requirements
Module: dp_ram_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 10, word address width.
- NUM_COL, 4, byte-enable columns.
- COL_WIDTH, 8, bits per column.
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- init_req_i, in, 1, request a RAM re-clear.
- init_done_o, out, 1, RAM cleared, arbitration active.
- mN_req_i (N=0,1), in, 1, master request.
- mN_we_i, in, 1, write (1) or read (0).
- mN_be_i, in, NUM_COL, byte enables.
- mN_addr_i, in, ADDR_WIDTH, word address.
- mN_wdata_i, in, DATA_WIDTH, write data.
- mN_gnt_o, out, 1, request accepted this cycle.
- mN_rvalid_o, out, 1, response valid.
- mN_rdata_o, out, DATA_WIDTH, response data.
- ram_en_o, out, 1, RAM port enable.
- ram_we_o, out, 1, RAM port write.
- ram_be_o, out, NUM_COL, RAM port byte enables.
- ram_addr_o, out, ADDR_WIDTH, RAM port address.
- ram_wdata_o, out, DATA_WIDTH, RAM port write data.
- ram_rdata_i, in, DATA_WIDTH, RAM read data, registered, 1-cycle latency.

Function
REQ-003 The FSM SHALL have two states, INIT and ARB.
REQ-004 In INIT, the block SHALL drive ram_en_o=1, ram_we_o=1, ram_be_o=all ones, ram_wdata_o=0 and ram_addr_o=clr_cnt; it SHALL hold init_done_o=0 and both grants at 0.
REQ-005 clr_cnt (ADDR_WIDTH bits) SHALL increment by one each INIT cycle; at clr_cnt=2^ADDR_WIDTH-1, the next state SHALL be ARB and clr_cnt SHALL wrap to 0.
REQ-006 In ARB, init_done_o SHALL be 1; a full clear takes exactly 2^ADDR_WIDTH cycles.
REQ-007 In ARB with init_req_i=1, the block SHALL issue no grant and drive ram_en_o=0 that cycle, and the next state SHALL be INIT with clr_cnt=0.
REQ-008 In ARB with init_req_i=0, grant SHALL be combinational in the same cycle as req:
- exactly one mN_req_i high: that master is granted;
- both high: the master not recorded in last_q is granted;
- neither high: ram_en_o=0.
REQ-009 last_q SHALL be updated to the granted index on every grant, and SHALL hold otherwise.
REQ-010 On a grant, the RAM port SHALL carry the granted master's we/be/addr/wdata with ram_en_o=1; ram_be_o SHALL equal mN_be_i when we=1, and all ones when we=0.
REQ-011 When ram_en_o=0, ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o SHALL be 0.
REQ-012 Response routing:
- Each grant (read or write) SHALL produce mN_rvalid_o=1 for exactly one cycle, exactly one cycle later, for the same master.
- mN_rdata_o SHALL equal ram_rdata_i while mN_rvalid_o=1, and 0 otherwise.
REQ-013 A grant in cycle t and a grant in cycle t+1 SHALL each produce their own response; back-to-back throughput SHALL be 1 access per cycle.
REQ-014 A response owed from the last ARB cycle SHALL still be delivered in the first INIT cycle.
REQ-015 The other master's rvalid SHALL remain 0 during any response.
REQ-016 Masters SHALL hold req and its fields stable until gnt; the block SHALL not buffer ungranted requests.

Reset
REQ-017 While rst=1 (asynchronous), the block SHALL force: state=INIT, clr_cnt=0, last_q=1 (m0 wins the first contention), init_done_o=0, all gnt and rvalid low, all rdata 0.
REQ-018 In-flight responses SHALL be discarded on reset.
REQ-019 When rst deasserts, the clear SHALL start at address 0 on the first clk edge.
REQ-020 An assertion of rst mid-clear SHALL restart the clear from address 0.

Verification
REQ-021 Reset release, ADDR_WIDTH=4 -> 16 INIT write cycles with addresses 0..15 and wdata 0; init_done_o=1 from cycle 17; a subsequent read of any address returns 0.
REQ-022 m0 writes 0xDEADBEEF to address 5 with be=4'b0011, then reads address 5 -> m0_rvalid_o asserted one cycle after each grant; read returns 0x0000BEEF.
REQ-023 m0 and m1 request continuously -> grants alternate m0,m1,m0,... starting with m0; each rvalid goes to the correct master one cycle later.
REQ-024 init_req_i asserted while m1_req_i=1 -> no grant that cycle; a clear runs for 2^ADDR_WIDTH cycles; m1 is granted on the first ARB cycle afterwards.
REQ-025 rst asserted while clr_cnt=7 and while a read response is pending -> rvalid never appears; the clear restarts at address 0.
REQ-026 m1 alone issues a read on a cycle immediately following an m0 write -> both rvalids are delivered on consecutive cycles with no bubble.
